// File: rtl/wbuart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and parity control constants.
package wbuart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE    = 2'b00;
  localparam int         PAR_ODD_BIT = 0;

  // Counter preload that lands the first sample in the middle of the start bit.
  function automatic logic [15:0] mid_bit_load(input logic [15:0] clk_div);
    return {1'b0, clk_div[15:1]} - 16'd1;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchroniser for the asynchronous receive line; resets to the idle (high) level.
module rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rx_frontend.sv
// UART receive front end: start detect, mid-bit sampling, parity and stop-bit checking.
// Optional WBUART_RX_MAJORITY_VOTE_EN: each sample is a 2-of-3 vote over the last three synced values.
//
// state  | meaning
// IDLE   | wait for armed line to go low
// START  | confirm start bit at mid-bit
// DATA   | shift in 7 or 8 data bits, LSB first
// PARITY | compare received parity bit with running parity
// STOP   | sample one or two stop bits, then report frame
module rx_frontend
  import wbuart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] cr_clk_div_i,
  input  logic        cr_ds_i,
  input  logic [1:0]  cr_p_i,
  input  logic        cr_s_i,
  input  logic        uart_rx_i,
  output logic [7:0]  dr_o,
  output logic        done_o,
  output logic        parity_error_o,
  output logic        frame_error_o
);

  logic rx_s;
  logic bit_s;

  rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (uart_rx_i),
    .q_o  (rx_s)
  );

`ifdef WBUART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rx_s};
    end
  end

  assign bit_s = (rx_s & hist_q[0]) | (rx_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign bit_s = rx_s;
`endif

  uart_state_e state_q;
  logic [15:0] cnt_q;
  logic [15:0] div_q;
  logic        ds_q;
  logic [1:0]  p_q;
  logic        s_q;
  logic [2:0]  bitcnt_q;
  logic        stopcnt_q;
  logic [7:0]  shift_q;
  logic        par_q;
  logic        perr_q;
  logic        ferr_q;
  logic        armed_q;
  logic [7:0]  dr_q;
  logic        done_q;
  logic        pe_q;
  logic        fe_q;

  logic        tick;
  logic        last_bit;
  logic [15:0] reload;

  assign tick     = (cnt_q == 16'd0);
  assign last_bit = ds_q ? (bitcnt_q == 3'd7) : (bitcnt_q == 3'd6);
  assign reload   = div_q - 16'd1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      ds_q      <= 1'b0;
      p_q       <= PAR_NONE;
      s_q       <= 1'b0;
      bitcnt_q  <= '0;
      stopcnt_q <= 1'b0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      armed_q   <= 1'b0;
      dr_q      <= '0;
      done_q    <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        cnt_q <= tick ? reload : cnt_q - 16'd1;
      end
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!armed_q) begin
            armed_q <= rx_s;
          end else if (!rx_s) begin
            state_q <= START;
            cnt_q   <= mid_bit_load(cr_clk_div_i);
            div_q   <= cr_clk_div_i;
            ds_q    <= cr_ds_i;
            p_q     <= cr_p_i;
            s_q     <= cr_s_i;
          end
        end
        START: begin
          if (tick) begin
            if (bit_s) begin
              state_q <= IDLE;
            end else begin
              state_q  <= DATA;
              bitcnt_q <= '0;
              shift_q  <= '0;
              par_q    <= p_q[PAR_ODD_BIT];
              perr_q   <= 1'b0;
              ferr_q   <= 1'b0;
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift_q[bitcnt_q] <= bit_s;
            par_q             <= par_q ^ bit_s;
            bitcnt_q          <= bitcnt_q + 3'd1;
            if (last_bit) begin
              state_q   <= (p_q != PAR_NONE) ? PARITY : STOP;
              stopcnt_q <= s_q;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            perr_q  <= (bit_s != par_q);
            state_q <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stopcnt_q) begin
              stopcnt_q <= 1'b0;
              ferr_q    <= ferr_q | ~bit_s;
            end else begin
              // Frame end: publish results and disarm until the line is seen high again.
              state_q <= IDLE;
              cnt_q   <= '0;
              armed_q <= 1'b0;
              done_q  <= 1'b1;
              dr_q    <= shift_q;
              pe_q    <= perr_q;
              fe_q    <= ferr_q | ~bit_s;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dr_o           = dr_q;
  assign done_o         = done_q;
  assign parity_error_o = pe_q;
  assign frame_error_o  = fe_q;

endmodule

// File: tb/tb_rx_frontend.sv
// Directed self-checking bench for rx_frontend at clk_div = 16.
module tb_rx_frontend;

  localparam int DIV = 16;

  logic        clk;
  logic        rst_n;
  logic [15:0] cr_clk_div;
  logic        cr_ds;
  logic [1:0]  cr_p;
  logic        cr_s;
  logic        uart_rx;
  logic [7:0]  dr;
  logic        done;
  logic        pe;
  logic        fe;

  int          total = 0;
  int          bad   = 0;
  int          done_cnt = 0;
  int          d0;
  logic [7:0]  cap_dr = '0;
  logic        cap_pe = 1'b0;
  logic        cap_fe = 1'b0;

  rx_frontend #(.SYNC_STAGES(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .cr_clk_div_i  (cr_clk_div),
    .cr_ds_i       (cr_ds),
    .cr_p_i        (cr_p),
    .cr_s_i        (cr_s),
    .uart_rx_i     (uart_rx),
    .dr_o          (dr),
    .done_o        (done),
    .parity_error_o(pe),
    .frame_error_o (fe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      cap_dr   <= dr;
      cap_pe   <= pe;
      cap_fe   <= fe;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    uart_rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    uart_rx = 1'b1;
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit par_en,
                            input bit odd, input bit flip_par, input int nstop,
                            input bit stop_low, input bit scramble);
    logic p;
    p = odd;
    bit_time(1'b0);
    if (scramble) begin
      cr_ds = ~cr_ds;
      cr_p  = 2'b11;
      cr_s  = ~cr_s;
    end
    for (int i = 0; i < nbits; i++) begin
      bit_time(data[i]);
      p = p ^ data[i];
    end
    if (par_en) bit_time(p ^ flip_par);
    for (int i = 0; i < nstop; i++) bit_time(~stop_low);
  endtask

  initial begin
    rst_n      = 1'b0;
    uart_rx    = 1'b1;
    cr_clk_div = 16'(DIV);
    cr_ds      = 1'b1;
    cr_p       = 2'b00;
    cr_s       = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_dr", {24'd0, dr}, 32'h0);
    check("reset_done", {31'd0, done}, 32'h0);
    check("reset_pe", {31'd0, pe}, 32'h0);
    check("reset_fe", {31'd0, fe}, 32'h0);
    rst_n = 1'b1;
    idle_bits(3);

    // 8N1 0xA5
    d0 = done_cnt;
    send_frame(8'hA5, 8, 0, 0, 0, 1, 0, 0);
    idle_bits(2);
    check("a5_done_cnt", done_cnt - d0, 32'd1);
    check("a5_dr", {24'd0, cap_dr}, 32'hA5);
    check("a5_pe", {31'd0, cap_pe}, 32'h0);
    check("a5_fe", {31'd0, cap_fe}, 32'h0);
    check("a5_dr_hold", {24'd0, dr}, 32'hA5);

    // 7E2 0x55, good then flipped parity
    cr_ds = 1'b0; cr_p = 2'b10; cr_s = 1'b1;
    d0 = done_cnt;
    send_frame(8'h55, 7, 1, 0, 0, 2, 0, 0);
    idle_bits(2);
    check("7e2_done_cnt", done_cnt - d0, 32'd1);
    check("7e2_dr", {24'd0, cap_dr}, 32'h55);
    check("7e2_pe", {31'd0, cap_pe}, 32'h0);
    check("7e2_fe", {31'd0, cap_fe}, 32'h0);
    d0 = done_cnt;
    send_frame(8'h55, 7, 1, 0, 1, 2, 0, 0);
    idle_bits(2);
    check("7e2f_done_cnt", done_cnt - d0, 32'd1);
    check("7e2f_dr", {24'd0, cap_dr}, 32'h55);
    check("7e2f_pe", {31'd0, cap_pe}, 32'h1);
    check("7e2f_fe", {31'd0, cap_fe}, 32'h0);

    // config changed mid-frame must not affect the frame
    cr_ds = 1'b1; cr_p = 2'b00; cr_s = 1'b0;
    d0 = done_cnt;
    send_frame(8'hA5, 8, 0, 0, 0, 1, 0, 1);
    idle_bits(3);
    cr_ds = 1'b1; cr_p = 2'b00; cr_s = 1'b0;
    check("latch_done_cnt", done_cnt - d0, 32'd1);
    check("latch_dr", {24'd0, cap_dr}, 32'hA5);
    check("latch_pe", {31'd0, cap_pe}, 32'h0);

    // reset at bit 3 aborts frame
    d0 = done_cnt;
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    uart_rx = 1'b0;
    repeat (DIV / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_dr", {24'd0, dr}, 32'h0);
    check("rst_mid_done", {31'd0, done}, 32'h0);
    rst_n = 1'b1;
    idle_bits(12);
    check("rst_mid_no_done", done_cnt - d0, 32'd0);
    d0 = done_cnt;
    send_frame(8'h81, 8, 0, 0, 0, 1, 0, 0);
    idle_bits(2);
    check("x81_done_cnt", done_cnt - d0, 32'd1);
    check("x81_dr", {24'd0, cap_dr}, 32'h81);
    check("x81_fe", {31'd0, cap_fe}, 32'h0);

    // 8O1 0x3C with low stop bit, then line held low
    cr_p = 2'b01;
    d0 = done_cnt;
    send_frame(8'h3C, 8, 1, 1, 0, 1, 1, 0);
    uart_rx = 1'b0;
    repeat (40 * DIV) @(negedge clk);
    check("3c_break_done_cnt", done_cnt - d0, 32'd1);
    check("3c_dr", {24'd0, cap_dr}, 32'h3C);
    check("3c_pe", {31'd0, cap_pe}, 32'h0);
    check("3c_fe", {31'd0, cap_fe}, 32'h1);
    idle_bits(2);
    check("3c_after_high_cnt", done_cnt - d0, 32'd1);

    // break starting from idle
    d0 = done_cnt;
    uart_rx = 1'b0;
    repeat (20 * DIV) @(negedge clk);
    check("brk_done_cnt", done_cnt - d0, 32'd1);
    check("brk_dr", {24'd0, cap_dr}, 32'h0);
    check("brk_fe", {31'd0, cap_fe}, 32'h1);
    check("brk_pe", {31'd0, cap_pe}, 32'h1);
    idle_bits(3);

    // 4-clock low glitch is a false start
    cr_p = 2'b00;
    d0 = done_cnt;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    idle_bits(3);
    check("glitch_no_done", done_cnt - d0, 32'd0);

`ifdef WBUART_RX_MAJORITY_VOTE_EN
    // 1-clock high glitch near mid of data bit 3 of 0x00 is outvoted
    d0 = done_cnt;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        uart_rx = 1'b0;
        repeat (9) @(negedge clk);
        uart_rx = 1'b1;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (DIV - 10) @(negedge clk);
      end else begin
        bit_time(1'b0);
      end
    end
    bit_time(1'b1);
    idle_bits(2);
    check("vote_done_cnt", done_cnt - d0, 32'd1);
    check("vote_dr", {24'd0, cap_dr}, 32'h0);
    check("vote_fe", {31'd0, cap_fe}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
